// File: rtl/radix2_div_arb_pkg.sv
// Shared types and result-field layout for the round-robin radix-2 divider arbiter.
package radix2_div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        FAULT = 3'd4
    } arb_state_t;

    // Result is packed {remainder, quotient}; the quotient sits at the bottom.
    localparam int unsigned RES_QUO_LSB = 0;

    function automatic int unsigned res_rem_lsb(input int unsigned data_w);
        return RES_QUO_LSB + data_w;
    endfunction

    // Quotient of a divide-by-zero is all-ones, built from this bit.
    localparam logic ZERO_DIV_QUO_BIT = 1'b1;

endpackage

// File: rtl/radix2_div_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin : pick
        int unsigned j;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[IDX_W'(j)]) begin
                found              = 1'b1;
                gnt[IDX_W'(j)]     = 1'b1;
                gnt_idx            = IDX_W'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/radix2_div_arbiter.sv
// Round-robin front end sharing one radix2_div among NUM_REQ requesters, with watchdog.
// Optional: define DIV_ARB_ZERO_BYPASS_EN to answer divide-by-zero locally without the divider.
module radix2_div_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_sign,
    input  logic [NUM_REQ*DATA_W-1:0]   req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [2*DATA_W-1:0]         rsp_result,
    output logic                        busy,
    output logic                        err_timeout,
    output logic                        div_opn_valid,
    output logic                        div_sign,
    output logic [DATA_W-1:0]           div_dividend,
    output logic [DATA_W-1:0]           div_divisor,
    input  logic                        div_res_valid,
    input  logic [2*DATA_W-1:0]         div_result
);
    import radix2_div_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned RES_W = 2 * DATA_W;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam int unsigned RES_REM_LSB = res_rem_lsb(DATA_W);
`endif

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [WD_W-1:0]     wdog_q, wdog_d, wdog_inc;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                sel_sign;
    logic [DATA_W-1:0]   sel_dvd, sel_dvs;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Operand select for the requester the picker chose.
    always_comb begin
        sel_sign = 1'b0;
        sel_dvd  = '0;
        sel_dvs  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[IDX_W'(i)]) begin
                sel_sign = req_sign[IDX_W'(i)];
                sel_dvd  = req_dividend[i*DATA_W +: DATA_W];
                sel_dvs  = req_divisor[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wdog_inc = (wdog_q == WD_W'(TIMEOUT)) ? wdog_q : wdog_q + WD_W'(1);

    // Next-state and accept logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        sign_d    = sign_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (pick_any && !rst) begin
                    req_ready = pick_gnt;
                    owner_d   = pick_gnt;
                    ptr_d     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    sign_d    = sel_sign;
                    dvd_d     = sel_dvd;
                    dvs_d     = sel_dvs;
                    wdog_d    = '0;
                    state_d   = ISSUE;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (sel_dvs == '0) begin
                        res_d[RES_REM_LSB +: DATA_W] = sel_dvd;
                        res_d[RES_QUO_LSB +: DATA_W] = {DATA_W{ZERO_DIV_QUO_BIT}};
                        state_d                      = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_res_valid) begin
                    res_d   = div_result;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WD_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            sign_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign div_opn_valid = (state_q == ISSUE);
    assign div_sign      = sign_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign rsp_valid     = (state_q == RESP) ? owner_q : '0;
    assign rsp_result    = (state_q == RESP) ? res_q : '0;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_radix2_div_arbiter.sv
// Directed bench for radix2_div_arbiter with a fixed-latency divider model.
module tb_radix2_div_arbiter;

    localparam int NR      = 4;
    localparam int DW      = 8;
    localparam int TO      = 32;
    localparam int DIV_LAT = 3;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_sign, rsp_valid;
    logic [NR*DW-1:0]  req_dividend, req_divisor;
    logic [2*DW-1:0]   rsp_result, div_result;
    logic              busy, err_timeout, div_opn_valid, div_sign, div_res_valid;
    logic [DW-1:0]     div_dividend, div_divisor;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    radix2_div_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .busy(busy), .err_timeout(err_timeout),
        .div_opn_valid(div_opn_valid), .div_sign(div_sign),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_res_valid(div_res_valid), .div_result(div_result)
    );

    // Divider model: res_valid DIV_LAT cycles after opn_valid; x/0 gives {x, all-ones}.
    logic [DIV_LAT-1:0] pipe;
    logic [DW-1:0]      ma = '0, mb = 8'd1;
    bit                 dm_en = 1'b1;
    bit                 stray = 1'b0;

    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else begin
            pipe <= {pipe[DIV_LAT-2:0], div_opn_valid & dm_en};
            if (div_opn_valid) begin
                ma <= div_dividend;
                mb <= div_divisor;
            end
        end
    end
    assign div_result    = (mb == 0) ? {ma, 8'hFF} : {ma % mb, ma / mb};
    assign div_res_valid = pipe[DIV_LAT-1] | stray;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic s, input logic [7:0] a, input logic [7:0] b);
        req_sign[id]             = s;
        req_dividend[id*DW +: DW] = a;
        req_divisor[id*DW +: DW]  = b;
        req_valid[id]            = 1'b1;
    endtask

    task automatic wait_ready(output logic [NR-1:0] rdy);
        int k;
        k = 0;
        #1;
        while (req_ready == 0 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        rdy = req_ready;
    endtask

    // Steps from the accept cycle to the response; drops 'drop' bits on the first step.
    task automatic wait_rsp(input logic [NR-1:0] drop, output logic [NR-1:0] v,
                            output logic [2*DW-1:0] r, output int k, output logic opn1,
                            output logic sgn1, output logic [DW-1:0] dvd1,
                            output bit busy_ok, output bit quiet);
        k = 0; busy_ok = 1'b1; quiet = 1'b1; opn1 = 1'b0; sgn1 = 1'b0; dvd1 = '0;
        do begin
            @(negedge clk);
            if (k == 0) req_valid = req_valid & ~drop;
            #1;
            k++;
            if (k == 1) begin
                opn1 = div_opn_valid;
                sgn1 = div_sign;
                dvd1 = div_dividend;
            end
            if (!busy) busy_ok = 1'b0;
            if (req_ready != 0) quiet = 1'b0;
        end while (rsp_valid == 0 && k < 80);
        v = rsp_valid;
        r = rsp_result;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int           id;
        logic         sgn;
        logic [7:0]   a;
        logic [7:0]   b;
        logic [15:0]  exp;
    } vec_t;

    vec_t            vecs[7];
    logic [7:0]      rr_a[4], rr_b[4];
    logic [15:0]     rr_exp[4];

    initial begin
        logic [NR-1:0]   rdy, v;
        logic [2*DW-1:0] r;
        int              k, g;
        logic            opn1, sgn1;
        logic [DW-1:0]   dvd1;
        bit              busy_ok, quiet, bad, bp;

        vecs[0] = '{0, 1'b0, 8'd100, 8'd7,  16'h020E};
        vecs[1] = '{1, 1'b0, 8'd200, 8'd9,  16'h0216};
        vecs[2] = '{2, 1'b0, 8'd255, 8'd16, 16'h0F0F};
        vecs[3] = '{3, 1'b0, 8'd5,   8'd10, 16'h0500};
        vecs[4] = '{1, 1'b1, 8'd0,   8'd3,  16'h0000};
        vecs[5] = '{2, 1'b0, 8'd255, 8'd1,  16'h00FF};
        vecs[6] = '{3, 1'b0, 8'd55,  8'd0,  16'h37FF};
        rr_a   = '{8'd100, 8'd200, 8'd255, 8'd50};
        rr_b   = '{8'd7, 8'd9, 8'd16, 8'd5};
        rr_exp = '{16'h020E, 16'h0216, 16'h0F0F, 16'h000A};

        rst = 1'b1; req_valid = '0; req_sign = '0; req_dividend = '0; req_divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_result", rsp_result, 0);
        chk("rst busy", busy, 0);
        chk("rst err_timeout", err_timeout, 0);
        chk("rst div_opn_valid", div_opn_valid, 0);
        chk("rst div_sign", div_sign, 0);
        chk("rst div_dividend", div_dividend, 0);
        chk("rst div_divisor", div_divisor, 0);

        // Single operations from the vector table.
        for (int i = 0; i < 7; i++) begin
            bp = BYPASS && (vecs[i].b == 0);
            @(negedge clk);
            set_req(vecs[i].id, vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_ready(rdy);
            chk($sformatf("v%0d ready", i), rdy, 32'(1 << vecs[i].id));
            wait_rsp(NR'(1 << vecs[i].id), v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
            chk($sformatf("v%0d opn_valid", i), opn1, bp ? 0 : 1);
            chk($sformatf("v%0d div_sign", i), sgn1, vecs[i].sgn);
            chk($sformatf("v%0d div_dividend", i), dvd1, vecs[i].a);
            chk($sformatf("v%0d latency", i), k, bp ? 1 : 2 + DIV_LAT);
            chk($sformatf("v%0d rsp_valid", i), v, 32'(1 << vecs[i].id));
            chk($sformatf("v%0d rsp_result", i), r, vecs[i].exp);
            chk($sformatf("v%0d busy held", i), busy_ok, 1);
            chk($sformatf("v%0d no ready while busy", i), quiet, 1);
            @(negedge clk); #1;
            chk($sformatf("v%0d idle after", i), {rsp_valid, busy}, 0);
        end

        // Round-robin with all four requesting continuously.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, rr_a[i], rr_b[i]);
        for (int n = 0; n < 5; n++) begin
            g = n % NR;
            wait_ready(rdy);
            chk($sformatf("rr%0d grant", n), rdy, 32'(1 << g));
            wait_rsp('0, v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
            chk($sformatf("rr%0d owner", n), v, 32'(1 << g));
            chk($sformatf("rr%0d result", n), r, rr_exp[g]);
            chk($sformatf("rr%0d no ready while busy", n), quiet, 1);
            if (n == 4) req_valid = '0;
        end

        // Request raised during RESP is taken in the following IDLE cycle.
        @(negedge clk);
        set_req(1, 1'b0, 8'd77, 8'd8);
        wait_ready(rdy);
        chk("b2b first grant", rdy, 32'b0010);
        wait_rsp(4'b0010, v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
        chk("b2b first rsp", v, 32'b0010);
        chk("b2b first result", r, 16'h0509);
        set_req(2, 1'b0, 8'd90, 8'd10);
        #1;
        chk("b2b ready in RESP", req_ready, 0);
        @(negedge clk); #1;
        chk("b2b ready in IDLE", req_ready, 32'b0100);
        wait_rsp(4'b0100, v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
        chk("b2b second rsp", v, 32'b0100);
        chk("b2b second result", r, 16'h0009);

        // Divider completion outside WAIT is ignored.
        @(negedge clk);
        stray = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (rsp_valid != 0 || busy) bad = 1'b1;
        end
        stray = 1'b0;
        chk("stray res_valid ignored", bad, 0);

        // Reset in WAIT drops the op and returns the pointer to 0.
        @(negedge clk);
        set_req(1, 1'b1, 8'd10, 8'd3);
        wait_ready(rdy);
        chk("mid-wait grant", rdy, 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("mid-wait busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid-wait rst busy", busy, 0);
        chk("mid-wait rst div ops", {div_sign, div_dividend, div_divisor, div_opn_valid}, 0);
        chk("mid-wait rst err", err_timeout, 0);
        bad = 1'b0;
        repeat (DIV_LAT + 3) begin
            @(negedge clk); #1;
            if (rsp_valid != 0 || busy) bad = 1'b1;
        end
        chk("mid-wait no response", bad, 0);
        set_req(3, 1'b0, 8'd9, 8'd9);
        set_req(0, 1'b0, 8'd60, 8'd7);
        wait_ready(rdy);
        chk("rst pointer grant", rdy, 32'b0001);
        wait_rsp(4'b1001, v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
        chk("post-rst rsp", v, 32'b0001);
        chk("post-rst result", r, 16'h0408);
        chk("post-rst latency", k, 2 + DIV_LAT);

        // Watchdog: divider never answers.
        dm_en = 1'b0;
        @(negedge clk);
        set_req(2, 1'b0, 8'd40, 8'd4);
        wait_ready(rdy);
        chk("to grant", rdy, 32'b0100);
        quiet = 1'b1;
        for (int i = 1; i <= TO + 2; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[0] = 1'b1;
            #1;
            if (req_ready != 0) quiet = 1'b0;
            if (i == TO + 1) chk("to err before", err_timeout, 0);
            if (i == TO + 2) chk("to err at TIMEOUT", err_timeout, 1);
        end
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (req_ready != 0 || rsp_valid != 0 || !busy || !err_timeout) bad = 1'b1;
        end
        chk("to no ready before fault", quiet, 1);
        chk("to fault terminal", bad, 0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        dm_en = 1'b1;
        #1;
        chk("to rst clears err", err_timeout, 0);
        chk("to rst clears busy", busy, 0);
        @(negedge clk);
        set_req(0, 1'b0, 8'd100, 8'd7);
        wait_ready(rdy);
        chk("after fault grant", rdy, 32'b0001);
        wait_rsp(4'b0001, v, r, k, opn1, sgn1, dvd1, busy_ok, quiet);
        chk("after fault result", {v, r}, {4'b0001, 16'h020E});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
